four_bit_full_adder: RTL and testbench

FOUR_BIT_FULL_ADDER -- requirements
Module: four_bit_full_adder

---
 rtl/four_bit_full_adder.sv | 61 ++++++
 tb/tb_four_bit_full_adder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/four_bit_full_adder.sv
// Registered ripple-carry adder: WIDTH full-adder cells feed one output register stage
// that also holds the carry-out, signed overflow and zero flags with a valid strobe.
module four_bit_full_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             out_valid,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;
  logic             r_valid;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      // Without a new operand the result registers keep the last answer.
      if (in_valid) begin
        r_sum      <= w_sum;
        r_cout     <= w_carry[WIDTH];
        r_overflow <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
        r_zero     <= (w_sum == '0);
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_four_bit_full_adder.sv
// Scoreboard bench: the driver pushes arithmetic-model results into a queue, and an
// independent monitor pops and compares them on every out_valid pulse.
module tb_four_bit_full_adder;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sum;
  logic         cout;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_valid;
  logic         out_valid;
  logic         overflow;
  logic         zero;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t held;

  four_bit_full_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sum(sum), .cout(cout), .a(a), .b(b), .cin(cin),
    .in_valid(in_valid), .out_valid(out_valid), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Plain integer arithmetic: unsigned total for sum/carry, signed range test for overflow.
  function automatic exp_t model(input int unsigned ia, input int unsigned ib, input int unsigned ic);
    exp_t        e;
    int unsigned total;
    int          sa, sb, ss;
    total  = ia + ib + ic;
    sa     = (ia >= 8) ? int'(ia) - 16 : int'(ia);
    sb     = (ib >= 8) ? int'(ib) - 16 : int'(ib);
    ss     = sa + sb + int'(ic);
    e.sum  = W'(total % 16);
    e.cout = (total >= 16);
    e.ovf  = (ss > 7) || (ss < -8);
    e.zero = ((total % 16) == 0);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; a = ia; b = ib; cin = ic;
    if (r) begin
      held = '0;
    end else if (v) begin
      e = model(ia, ib, ic);
      q.push_back(e);
      held = e;
    end
  endtask

  task automatic check_cleared(input string tag);
    @(negedge clk);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_cout"}, cout, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_zero"}, zero, 0);
    check({tag, "_valid"}, out_valid, 0);
  endtask

  task automatic check_hold(input string tag);
    drive(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    drive(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_sum"}, sum, held.sum);
    check({tag, "_cout"}, cout, held.cout);
    check({tag, "_ovf"}, overflow, held.ovf);
    check({tag, "_zero"}, zero, held.zero);
  endtask

  // Monitor: any out_valid without a pending expectation is a spurious pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          e = q.pop_front();
          check("sum", sum, e.sum);
          check("cout", cout, e.cout);
          check("overflow", overflow, e.ovf);
          check("zero", zero, e.zero);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] va [12];
    logic [W-1:0] vb [12];
    logic         vc [12];
    va = '{4'b1000, 4'b1000, 4'b1010, 4'b1110, 4'b1010, 4'b0010,
           4'b0001, 4'b1000, 4'b0010, 4'b1111, 4'b0000, 4'b0111};
    vb = '{4'b0010, 4'b1000, 4'b1011, 4'b1111, 4'b1101, 4'b1000,
           4'b0111, 4'b1101, 4'b0111, 4'b1111, 4'b0000, 4'b1000};
    vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset while an operand is offered: the operand must be discarded.
    rst = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b1;
    held = '0;
    repeat (2) @(posedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_cleared("reset");

    // Directed vectors, back to back, then idle to confirm the last result holds.
    for (int i = 0; i < 12; i++) drive(1'b1, va[i], vb[i], vc[i], 1'b0);
    check_hold("hold_directed");

    // Randomised stream with gaps.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
    check_hold("hold_random");

    // Mid-stream reset with in_valid high, then resume immediately.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      check_cleared("midreset");
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
    check_hold("hold_after_reset");

    // Drain: every expectation must have been matched by an out_valid pulse.
    repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("scoreboard_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
